// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
// Shares one memory read port between instruction fetch (F) and the load
// unit (L). Only one read is outstanding at a time. When both ports are
// eligible in the same cycle, the port that did not win last time is granted.
// Read data goes back to the granted port with a registered one-cycle valid pulse.
//
// Parameters:
//   AW         address width (F_Addr, L_Addr, RAddr)
//   DW         data width (F_Data, L_Data, RData)
//   TO_CYCLES  watchdog limit in BUSY cycles. Must be >= 2. Only used when
//              MEMARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk, rst         clock (posedge) and asynchronous active-high reset
//   F_Req/F_Addr     fetch request (held until F_Vld) and address
//   F_Vld/F_Data     fetch response pulse and data (data holds between pulses)
//   L_Req/L_Addr     load request (held until L_Vld) and address
//   L_Vld/L_Data     load response pulse and data (data holds between pulses)
//   RRdy/RAddr       registered memory read request and address
//   RVld/RData       memory response pulse and data
//   Busy             high while a read is outstanding
//   Err              one-cycle watchdog timeout pulse (0 when watchdog not built)
//
// Build option:
//   MEMARB_TIMEOUT_EN  when defined, builds a BUSY watchdog. If memory does not
//                      respond in time, the watchdog returns a zero-data response
//                      and pulses Err.
//
// States:
//   state | meaning
//   IDLE  | no read outstanding; arbitrate eligible requests
//   BUSY  | read issued to memory; waiting for RVld (or watchdog)

module mem_read_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          F_Req,
    input  logic [AW-1:0] F_Addr,
    output logic          F_Vld,
    output logic [DW-1:0] F_Data,
    input  logic          L_Req,
    input  logic [AW-1:0] L_Addr,
    output logic          L_Vld,
    output logic [DW-1:0] L_Data,
    output logic          RRdy,
    output logic [AW-1:0] RAddr,
    input  logic          RVld,
    input  logic [DW-1:0] RData,
    output logic          Busy,
    output logic          Err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_L = 1'b1;

    if (TO_CYCLES < 2) begin : g_to_cycles_check
        $error("mem_read_arbiter: TO_CYCLES must be at least 2");
    end

    logic [0:0]    state_q,  state_d;
    logic          last_q,   last_d;
    logic          gnt_q,    gnt_d;
    logic          rrdy_q,   rrdy_d;
    logic [AW-1:0] raddr_q,  raddr_d;
    logic          f_vld_q,  f_vld_d;
    logic [DW-1:0] f_data_q, f_data_d;
    logic          l_vld_q,  l_vld_d;
    logic [DW-1:0] l_data_q, l_data_d;
    logic          err_q,    err_d;

    logic          f_elig;
    logic          l_elig;
    logic          grant_l;
    logic          timeout;
    logic [DW-1:0] resp_data;

    // While a port sees its own Vld pulse, its Req is still high from the
    // finished transfer. Masking it here prevents a second, duplicate read.
    assign f_elig  = F_Req && !f_vld_q;
    assign l_elig  = L_Req && !l_vld_q;
    assign grant_l = l_elig && (!f_elig || (last_q == PORT_F));

`ifdef MEMARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // RVld in the same cycle as the limit wins; the timeout only fires without it.
    assign timeout = (state_q == ST_BUSY) && !RVld && (cnt_q == TO_LAST);

    // Held at zero in IDLE, so every BUSY entry starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (!RVld && !timeout) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // A timeout completes the read with zero data.
    assign resp_data = RVld ? RData : '0;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        rrdy_d   = rrdy_q;
        raddr_d  = raddr_q;
        f_data_d = f_data_q;
        l_data_d = l_data_q;
        f_vld_d  = 1'b0;
        l_vld_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (f_elig || l_elig) begin
                    gnt_d   = grant_l ? PORT_L : PORT_F;
                    last_d  = grant_l ? PORT_L : PORT_F;
                    raddr_d = grant_l ? L_Addr : F_Addr;
                    rrdy_d  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (RVld || timeout) begin
                    rrdy_d  = 1'b0;
                    err_d   = timeout;
                    state_d = ST_IDLE;
                    if (gnt_q == PORT_L) begin
                        l_vld_d  = 1'b1;
                        l_data_d = resp_data;
                    end else begin
                        f_vld_d  = 1'b1;
                        f_data_d = resp_data;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rrdy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= PORT_L;
            gnt_q    <= PORT_F;
            rrdy_q   <= 1'b0;
            raddr_q  <= '0;
            f_vld_q  <= 1'b0;
            f_data_q <= '0;
            l_vld_q  <= 1'b0;
            l_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            rrdy_q   <= rrdy_d;
            raddr_q  <= raddr_d;
            f_vld_q  <= f_vld_d;
            f_data_q <= f_data_d;
            l_vld_q  <= l_vld_d;
            l_data_q <= l_data_d;
            err_q    <= err_d;
        end
    end

    assign F_Vld  = f_vld_q;
    assign F_Data = f_data_q;
    assign L_Vld  = l_vld_q;
    assign L_Data = l_data_q;
    assign RRdy   = rrdy_q;
    assign RAddr  = raddr_q;
    assign Busy   = (state_q == ST_BUSY);
    assign Err    = err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios plus a
// randomized two-requester run checked against a transaction-level model.
module tb_mem_read_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        F_Req = 1'b0, L_Req = 1'b0;
    logic [31:0] F_Addr = '0, L_Addr = '0;
    logic        F_Vld, L_Vld, RRdy, Busy, Err;
    logic [31:0] F_Data, L_Data, RAddr;
    logic        RVld = 1'b0;
    logic [31:0] RData = '0;

    int checks = 0;
    int errors = 0;
    int model_last = 1;   // 0 = F, 1 = L; port that won the previous grant

    logic [31:0] mem [0:255];
    logic mem_stall = 1'b0;
    logic rand_lat  = 1'b0;
    logic spur      = 1'b0;
    int   seen = 0;
    int   extra = 0;

    mem_read_arbiter #(.AW(32), .DW(32), .TO_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .F_Req(F_Req), .F_Addr(F_Addr), .F_Vld(F_Vld), .F_Data(F_Data),
        .L_Req(L_Req), .L_Addr(L_Addr), .L_Vld(L_Vld), .L_Data(L_Data),
        .RRdy(RRdy), .RAddr(RAddr), .RVld(RVld), .RData(RData),
        .Busy(Busy), .Err(Err)
    );

    always #5 clk = ~clk;

    // Memory model: responds on the second cycle it sees RRdy (plus optional
    // random extra delay), with a one-cycle RVld pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                RVld = 1'b0; seen = 0;
            end else if (spur) begin
                RVld = 1'b1; RData = 32'hDEAD_BEEF; spur = 1'b0;
            end else if (RVld) begin
                RVld = 1'b0; seen = 0;
            end else if (RRdy && !mem_stall) begin
                seen++;
                if (seen >= 2 + extra) begin
                    RVld = 1'b1; RData = mem[RAddr[9:2]];
                end
            end else if (!RRdy) begin
                seen = 0;
                extra = rand_lat ? int'($urandom_range(0, 2)) : 0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; F_Req = 1'b0; L_Req = 1'b0; F_Addr = '0; L_Addr = '0;
        mem_stall = 1'b0; spur = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1;
    endtask

    function automatic logic port_vld(input int p);
        return (p == 0) ? F_Vld : L_Vld;
    endfunction

    task automatic set_req(input int p, input logic v);
        if (p == 0) F_Req = v; else L_Req = v;
    endtask

    task automatic set_addr(input int p, input logic [31:0] a);
        if (p == 0) F_Addr = a; else L_Addr = a;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [7:0] idx;
        idx = 8'($urandom_range(0, 255));
        return {22'b0, idx, 2'b00};
    endfunction

    task automatic test_reset;
        #1;
        checks++;
        if ({F_Vld, L_Vld, RRdy, Busy, Err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b, required 00000", {F_Vld, L_Vld, RRdy, Busy, Err});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({F_Data, L_Data, RAddr} !== 96'b0) begin
            errors++; $display("FAIL reset_data: F_Data %h L_Data %h RAddr %h, required all 0", F_Data, L_Data, RAddr);
        end
        checks++;
        if ({F_Vld, L_Vld, RRdy, Busy, Err} !== 5'b0) begin
            errors++; $display("FAIL reset_idle: got %b, required 00000", {F_Vld, L_Vld, RRdy, Busy, Err});
        end
    endtask

    task automatic test_single_fetch;
        int busy_cnt = 0, fv_cnt = 0, lv_cnt = 0, rrdy_edge = -1, fv_edge = -1;
        logic [31:0] fdata = '0, raddr0 = '0;
        do_reset();
        mem[1] = 32'h0000_0013;
        @(negedge clk); F_Req = 1'b1; F_Addr = 32'd4;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (Busy) busy_cnt++;
            if (RRdy && rrdy_edge < 0) begin rrdy_edge = c; raddr0 = RAddr; end
            if (F_Vld) begin fv_cnt++; fv_edge = c; fdata = F_Data; end
            if (L_Vld) lv_cnt++;
            @(negedge clk);
            if (F_Vld) F_Req = 1'b0;
        end
        checks++;
        if (rrdy_edge != 1 || raddr0 !== 32'd4) begin
            errors++; $display("FAIL single_rrdy: edge %0d addr %h, required edge 1 addr 4", rrdy_edge, raddr0);
        end
        checks++;
        if (fv_cnt != 1 || fv_edge != 3 || fdata !== 32'h13) begin
            errors++; $display("FAIL single_fvld: count %0d edge %0d data %h, required 1 / 3 / 00000013", fv_cnt, fv_edge, fdata);
        end
        checks++;
        if (lv_cnt != 0 || busy_cnt != 2) begin
            errors++; $display("FAIL single_busy: L_Vld count %0d busy cycles %0d, required 0 / 2", lv_cnt, busy_cnt);
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] addrs [$];
        int fv_edge = -1, lv_edge = -1;
        logic [31:0] fd = '0, ld = '0;
        logic prev_rrdy = 1'b0;
        do_reset();
        mem[2] = 32'hA5A5_0002; mem[3] = 32'hB0B0_0003;
        @(negedge clk); F_Req = 1'b1; F_Addr = 32'd8; L_Req = 1'b1; L_Addr = 32'd12;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (RRdy && !prev_rrdy) addrs.push_back(RAddr);
            prev_rrdy = RRdy;
            if (F_Vld) begin fv_edge = c; fd = F_Data; end
            if (L_Vld) begin lv_edge = c; ld = L_Data; end
            @(negedge clk);
            if (F_Vld) F_Req = 1'b0;
            if (L_Vld) L_Req = 1'b0;
        end
        checks++;
        if (addrs.size() != 2 || addrs[0] !== 32'd8 || addrs[1] !== 32'd12) begin
            errors++; $display("FAIL simul_raddr: %0d reads, first %h, required reads 8 then 12", addrs.size(),
                               (addrs.size() > 0) ? addrs[0] : 32'hFFFF_FFFF);
        end
        checks++;
        if (fv_edge != 3 || lv_edge != 6 || fd !== 32'hA5A5_0002 || ld !== 32'hB0B0_0003) begin
            errors++; $display("FAIL simul_vld: F edge %0d data %h, L edge %0d data %h, required 3/a5a50002 6/b0b00003",
                               fv_edge, fd, lv_edge, ld);
        end
    endtask

    task automatic test_contention;
        int order [$];
        int edges [$];
        logic bad = 1'b0;
        do_reset();
        @(negedge clk); F_Req = 1'b1; F_Addr = 32'd8; L_Req = 1'b1; L_Addr = 32'd12;
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk); #1;
            if (F_Vld) begin order.push_back(0); edges.push_back(c); end
            if (L_Vld) begin order.push_back(1); edges.push_back(c); end
        end
        F_Req = 1'b0; L_Req = 1'b0;
        checks++;
        if (order.size() != 6) begin
            errors++; $display("FAIL contention_count: %0d responses, required 6", order.size());
        end else begin
            for (int i = 0; i < 6; i++)
                if (order[i] != (i % 2) || edges[i] != 3 * (i + 1)) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++; $display("FAIL contention_order: ports %0d%0d%0d%0d%0d%0d, required 010101 at 3-cycle spacing",
                                   order[0], order[1], order[2], order[3], order[4], order[5]);
            end
        end
    endtask

    task automatic test_stale_mask;
        int reads = 0, fv = 0, stale = 0;
        logic prev_rrdy = 1'b0;
        logic [31:0] fd = '0;
        do_reset();
        mem[5] = 32'h5555_0005;
        @(negedge clk); F_Req = 1'b1; F_Addr = 32'd20;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (RRdy && !prev_rrdy) reads++;
            prev_rrdy = RRdy;
            if (F_Vld) begin fv++; fd = F_Data; end
            @(negedge clk);
            if (F_Vld) stale = 1;
            else if (stale == 1) begin F_Req = 1'b0; stale = 2; end
        end
        checks++;
        if (reads != 1 || fv != 1 || fd !== 32'h5555_0005) begin
            errors++; $display("FAIL stale_mask: reads %0d F_Vld %0d data %h, required 1 / 1 / 55550005", reads, fv, fd);
        end
    endtask

    task automatic test_spurious;
        int bad = 0;
        do_reset();
        @(negedge clk); spur = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (F_Vld || L_Vld || Busy || RRdy || Err) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL spurious_rvld: %0d cycles with activity, required 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        int k = 0;
        do_reset();
        mem[6] = 32'h6666_0006;
        @(negedge clk); F_Req = 1'b1; F_Addr = 32'd24;
        @(posedge clk); #1;
        checks++;
        if (RRdy !== 1'b1 || Busy !== 1'b1) begin
            errors++; $display("FAIL midrst_grant: RRdy %b Busy %b, required 1 1", RRdy, Busy);
        end
        @(negedge clk); rst = 1'b1; F_Req = 1'b0;
        #1;
        checks++;
        if ({RRdy, Busy, F_Vld, L_Vld} !== 4'b0) begin
            errors++; $display("FAIL midrst_async: RRdy/Busy/F_Vld/L_Vld %b, required 0000", {RRdy, Busy, F_Vld, L_Vld});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (Busy !== 1'b0 || RRdy !== 1'b0 || F_Vld !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: Busy %b RRdy %b F_Vld %b, required 0 0 0", Busy, RRdy, F_Vld);
        end
        @(negedge clk); F_Req = 1'b1;
        do begin @(negedge clk); k++; end while (!F_Vld && k < 20);
        F_Req = 1'b0;
        checks++;
        if (!F_Vld || F_Data !== 32'h6666_0006) begin
            errors++; $display("FAIL midrst_rereq: F_Vld %b data %h, required 1 66660006", F_Vld, F_Data);
        end
    endtask

`ifdef MEMARB_TIMEOUT_EN
    task automatic test_timeout;
        int busy_cnt = 0, err_cnt = 0, lv_cnt = 0, err_edge = -1, k = 0;
        logic [31:0] ld = 32'hFFFF_FFFF;
        logic rrdy_at = 1'b1;
        do_reset();
        @(negedge clk); L_Req = 1'b1; L_Addr = 32'd12;
        do begin @(negedge clk); k++; end while (!L_Vld && k < 20);
        L_Req = 1'b0;
        checks++;
        if (L_Data !== mem[3]) begin
            errors++; $display("FAIL timeout_preload: L_Data %h, required %h", L_Data, mem[3]);
        end
        @(negedge clk); mem_stall = 1'b1; L_Req = 1'b1; L_Addr = 32'd16;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (Busy) busy_cnt++;
            if (Err) begin err_cnt++; err_edge = c; rrdy_at = RRdy; end
            if (L_Vld) begin lv_cnt++; ld = L_Data; end
            @(negedge clk);
            if (L_Vld) L_Req = 1'b0;
        end
        mem_stall = 1'b0;
        checks++;
        if (busy_cnt != 4 || err_cnt != 1 || err_edge != 5 || rrdy_at !== 1'b0) begin
            errors++; $display("FAIL timeout_err: busy %0d err %0d at edge %0d RRdy %b, required 4 / 1 / 5 / 0",
                               busy_cnt, err_cnt, err_edge, rrdy_at);
        end
        checks++;
        if (lv_cnt != 1 || ld !== 32'h0) begin
            errors++; $display("FAIL timeout_vld: L_Vld %0d data %h, required 1 / 00000000", lv_cnt, ld);
        end
    endtask
`else
    task automatic test_no_timeout;
        int busy_cnt = 0, err_cnt = 0;
        do_reset();
        @(negedge clk); mem_stall = 1'b1; L_Req = 1'b1; L_Addr = 32'd16;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (Busy) busy_cnt++;
            if (Err || L_Vld) err_cnt++;
        end
        checks++;
        if (busy_cnt != 80 || err_cnt != 0) begin
            errors++; $display("FAIL no_timeout: busy %0d err/vld %0d, required 80 / 0", busy_cnt, err_cnt);
        end
        do_reset();
    endtask
`endif

    // One requester: issues nreq reads, finishing each one by dropping Req,
    // changing address (back-to-back), or holding a stale Req for one cycle.
    task automatic run_port(input int p, input int nreq);
        int n = 0, k, mode;
        logic hold;
        while (n < nreq) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            set_addr(p, rand_addr()); set_req(p, 1'b1);
            hold = 1'b1;
            while (hold) begin
                k = 0;
                do begin @(negedge clk); k++; end while (!port_vld(p) && k < 300);
                checks++;
                if (!port_vld(p)) begin
                    errors++; $display("FAIL rand_wait port %0d: no Vld after %0d cycles, required a response", p, k);
                    n = nreq; hold = 1'b0; set_req(p, 1'b0);
                end else begin
                    n++;
                    mode = $urandom_range(0, 2);
                    if (mode == 0 || n >= nreq) begin
                        set_req(p, 1'b0);
                    end else if (mode == 1) begin
                        set_addr(p, rand_addr());
                    end else begin
                        @(negedge clk); set_req(p, 1'b0);
                    end
                    hold = (mode == 1) && (n < nreq);
                end
            end
        end
        set_req(p, 1'b0);
    endtask

    task automatic test_random;
        localparam int NREQ = 15;
        logic done_f = 1'b0, done_l = 1'b0;
        do_reset();
        rand_lat = 1'b1;
        fork
            begin run_port(0, NREQ); done_f = 1'b1; end
            begin run_port(1, NREQ); done_l = 1'b1; end
            begin
                int exp_port [$];
                logic [31:0] exp_addr [$];
                logic pf = 1'b0, pl = 1'b0, pr = 1'b0, fe, le;
                int cyc = 0, win, got, nf = 0, nl = 0;
                logic [31:0] wa, gd;
                while (!(done_f && done_l && exp_port.size() == 0) && cyc < 4000) begin
                    @(posedge clk); #1; cyc++;
                    if (RRdy && !pr) begin
                        fe = F_Req && !pf; le = L_Req && !pl;
                        checks++;
                        if (!(fe || le)) begin
                            errors++; $display("FAIL rand_grant: read issued with no eligible requester at cycle %0d", cyc);
                        end else begin
                            win = (fe && le) ? (1 - model_last) : (fe ? 0 : 1);
                            model_last = win;
                            wa = (win == 0) ? F_Addr : L_Addr;
                            checks++;
                            if (RAddr !== wa) begin
                                errors++; $display("FAIL rand_raddr: RAddr %h, required %h (port %0d)", RAddr, wa, win);
                            end
                            exp_port.push_back(win); exp_addr.push_back(wa);
                        end
                    end
                    if (F_Vld || L_Vld) begin
                        checks++;
                        if ((F_Vld && L_Vld) || exp_port.size() == 0) begin
                            errors++; $display("FAIL rand_vld: F_Vld %b L_Vld %b with %0d expected, required one pulse for a pending read",
                                               F_Vld, L_Vld, exp_port.size());
                        end else begin
                            got = F_Vld ? 0 : 1;
                            gd  = F_Vld ? F_Data : L_Data;
                            if (got == 0) nf++; else nl++;
                            wa  = exp_addr.pop_front();
                            win = exp_port.pop_front();
                            checks++;
                            if (got != win || gd !== mem[wa[9:2]]) begin
                                errors++; $display("FAIL rand_data: port %0d data %h, required port %0d data %h",
                                                   got, gd, win, mem[wa[9:2]]);
                            end
                        end
                    end
                    pf = F_Vld; pl = L_Vld; pr = RRdy;
                end
                checks++;
                if (cyc >= 4000 || nf != NREQ || nl != NREQ) begin
                    errors++; $display("FAIL rand_totals: F %0d L %0d responses in %0d cycles, required %0d each", nf, nl, cyc, NREQ);
                end
            end
        join
        rand_lat = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_contention();
        test_stale_mask();
        test_spurious();
        test_reset_mid();
`ifdef MEMARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
